// File: rtl/button_counter_pkg.sv
// Shared definitions for the button counter: seven-segment glyphs (active-low
// {g,f,e,d,c,b,a}), the blank pattern and the count radix.
package button_counter_pkg;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_BCD = 1'b1
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/pb_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer and a
// single-cycle pulse on each accepted press.
module pb_debounce_pulse #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic          armed;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      warm    <= '0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop here samples pre-edge values.
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      warm    <= {warm[0], 1'b1};
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // A button held through reset must be seen released before it can fire.
      if (warm[1] && !sync2 && !level) armed <= 1'b1;
    end
  end

  assign pulse = armed & level & ~level_q;

endmodule

// File: rtl/button_counter_nhex.sv
// Up/down/clear counter with hex or BCD radix, shown on a multiplexed
// N-digit seven-segment display with optional leading-zero blanking.
module button_counter_nhex
  import button_counter_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNC,
  input  logic       mode,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       DP,
  output logic [7:0] AN
);

  localparam int CW = 4 * N_DIGITS;
  localparam int RW = $clog2(REFRESH_CYCLES + 1);

  logic up, down, clr;

  pb_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(CLK100MHZ), .rst_n(reset), .btn(BTNU), .pulse(up));
  pb_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk(CLK100MHZ), .rst_n(reset), .btn(BTND), .pulse(down));
  pb_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk(CLK100MHZ), .rst_n(reset), .btn(BTNC), .pulse(clr));

  logic          mode_s1, mode_s2, mode_q;
  mode_e         radix;
  logic [CW-1:0] count, bcd_inc, bcd_dec;
  logic          inc_carry, dec_borrow;

  assign radix = mode_e'(mode_s2);

  always_comb begin
    // NOTE: blocking assignments in combinational logic, each output defaulted first so no latch is inferred.
    bcd_inc    = count;
    bcd_dec    = count;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (inc_carry) begin
        if (count[4*i +: 4] >= 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count[4*i +: 4] == 4'd0) bcd_dec[4*i +: 4] = 4'd9;
        else begin
          bcd_dec[4*i +: 4] = (count[4*i +: 4] > 4'd9) ? 4'd9 : count[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
      count   <= '0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
      // Clear wins; opposing up/down pulses cancel out.
      if (clr || (mode_s2 != mode_q)) count <= '0;
      else if (up && !down) count <= (radix == MODE_BCD) ? bcd_inc : count + CW'(1);
      else if (down && !up) count <= (radix == MODE_BCD) ? bcd_dec : count - CW'(1);
    end
  end

  logic [RW-1:0] ref_cnt;
  logic [2:0]    idx, idx_n, msd;
  logic [3:0]    digit;
  logic [7:0]    an_n;
  logic [6:0]    seg_n;

  always_comb begin
    idx_n = idx;
    if (ref_cnt == RW'(REFRESH_CYCLES - 1))
      idx_n = (idx == 3'(N_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    msd   = 3'd0;
    digit = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i > 0 && count[4*i +: 4] != 4'd0) msd = 3'(i);
      if (idx_n == 3'(i)) digit = count[4*i +: 4];
    end
    an_n        = 8'hFF;
    an_n[idx_n] = 1'b0;
    seg_n       = (blank_lz && idx_n > msd) ? SEG_BLANK : SEG_GLYPH[digit];
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      AN      <= 8'hFF;
      seg     <= SEG_BLANK;
    end else begin
      ref_cnt <= (ref_cnt == RW'(REFRESH_CYCLES - 1)) ? '0 : ref_cnt + RW'(1);
      idx     <= idx_n;
      AN      <= an_n;
      seg     <= seg_n;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_button_counter_nhex.sv
// Directed bench for button_counter_nhex: counting in both radices, debounce
// latency, button priority, display scan/blanking and reset behaviour.
module tb_button_counter_nhex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnu, btnd, btnc, mode, blank_lz;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic [7:0] an, an2;

  int n_pass = 0, n_fail = 0, n_total = 0;

  logic [6:0] disp [4];
  logic       an2_high;

  always #5 clk = ~clk;

  button_counter_nhex #(.N_DIGITS(4), .DEB_CYCLES(4), .REFRESH_CYCLES(3)) dut (
    .CLK100MHZ(clk), .reset(rst_n), .BTNU(btnu), .BTND(btnd), .BTNC(btnc),
    .mode(mode), .blank_lz(blank_lz), .seg(seg), .DP(dp), .AN(an));

  button_counter_nhex #(.N_DIGITS(2), .DEB_CYCLES(4), .REFRESH_CYCLES(3)) dut2 (
    .CLK100MHZ(clk), .reset(rst_n), .BTNU(btnu), .BTND(btnd), .BTNC(btnc),
    .mode(mode), .blank_lz(blank_lz), .seg(seg2), .DP(dp2), .AN(an2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the chosen buttons long enough to be accepted, then release fully.
  task automatic press(input logic u, input logic d, input logic c);
    btnu = u; btnd = d; btnc = c;
    cycles(10);
    btnu = 1'b0; btnd = 1'b0; btnc = 1'b0;
    cycles(10);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic capture();
    an2_high = 1'b1;
    for (int k = 0; k < 4; k++) disp[k] = 7'bx;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (an == ~(8'h01 << k)) disp[k] = seg;
      if (an2[7:2] !== 6'h3F) an2_high = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; btnu = 1'b0; btnd = 1'b0; btnc = 1'b0; mode = 1'b0; blank_lz = 1'b0;
    cycles(3);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_an_n2", 32'(an2), 32'hFF);

    rst_n = 1'b1;
    cycles(1);
    check("first_an", 32'(an), 32'hFE);
    check("first_seg", 32'(seg), 32'h40);
    check("first_an_n2", 32'(an2), 32'hFE);
    cycles(4);

    press_up(17);
    check("hex_up17", 32'(dut.count), 32'h0011);
    capture();
    check("disp0_11", 32'(disp[0]), 32'h79);
    check("disp1_11", 32'(disp[1]), 32'h79);
    check("disp2_11", 32'(disp[2]), 32'h40);
    check("disp3_11", 32'(disp[3]), 32'h40);

    // Three one-cycle glitches, then a stable press.
    for (int g = 0; g < 3; g++) begin
      btnu = 1'b1; cycles(1);
      btnu = 1'b0; cycles(1);
    end
    btnu = 1'b1;
    cycles(6);
    check("bounce_lat6", 32'(dut.count), 32'h0011);
    cycles(1);
    check("bounce_lat7", 32'(dut.count), 32'h0012);
    cycles(6);
    btnu = 1'b0;
    cycles(12);
    check("bounce_once", 32'(dut.count), 32'h0012);

    press(1'b0, 1'b0, 1'b1);
    check("clear", 32'(dut.count), 32'h0000);
    press(1'b0, 1'b1, 1'b0);
    check("hex_wrap_dn", 32'(dut.count), 32'hFFFF);
    press(1'b1, 1'b0, 1'b0);
    check("hex_wrap_up", 32'(dut.count), 32'h0000);

    press_up(3);
    press(1'b1, 1'b1, 1'b0);
    check("up_dn_same", 32'(dut.count), 32'h0003);
    press(1'b1, 1'b0, 1'b1);
    check("clr_over_up", 32'(dut.count), 32'h0000);

    press_up(5);
    blank_lz = 1'b1;
    capture();
    check("blank_d0", 32'(disp[0]), 32'h12);
    check("blank_d1", 32'(disp[1]), 32'h7F);
    check("blank_d2", 32'(disp[2]), 32'h7F);
    check("blank_d3", 32'(disp[3]), 32'h7F);
    check("n2_an_high", 32'(an2_high), 32'h1);
    blank_lz = 1'b0;

    mode = 1'b1;
    cycles(5);
    check("mode_clr_bcd", 32'(dut.count), 32'h0000);
    press(1'b0, 1'b1, 1'b0);
    check("bcd_wrap_dn", 32'(dut.count), 32'h9999);
    press(1'b1, 1'b0, 1'b0);
    check("bcd_wrap_up", 32'(dut.count), 32'h0000);
    press_up(9);
    check("bcd_9", 32'(dut.count), 32'h0009);
    press_up(1);
    check("bcd_10", 32'(dut.count), 32'h0010);
    press_up(89);
    check("bcd_99", 32'(dut.count), 32'h0099);
    press_up(1);
    check("bcd_100", 32'(dut.count), 32'h0100);
    mode = 1'b0;
    cycles(5);
    check("mode_clr_hex", 32'(dut.count), 32'h0000);

    // Reset mid-scan with BTNU held down.
    btnu = 1'b1;
    cycles(15);
    check("held_inc", 32'(dut.count), 32'h0001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hFF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_cnt", 32'(dut.count), 32'h0000);
    cycles(3);
    rst_n = 1'b1;
    cycles(30);
    check("held_no_inc", 32'(dut.count), 32'h0000);
    btnu = 1'b0;
    cycles(12);
    press_up(1);
    check("repress_inc", 32'(dut.count), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
